// File: rtl/xor_parity_accumulator.sv
// Accumulates the bitwise XOR, parity and saturating word count of valid/ready framed input.
// Define XOR_PARITY_OVERLAP_EN to accept the next frame's first word on the result handoff edge.
module xor_parity_accumulator #(
  parameter int W     = 8,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     z,
  output logic             p,
  output logic [LEN_W-1:0] count,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t             state_reg, state_next;
  logic [W-1:0]       acc_reg, acc_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic               sat_acc_reg, sat_acc_next;
  logic [W-1:0]       z_reg, z_next;
  logic               p_reg, p_next;
  logic [LEN_W-1:0]   cnt_out_reg, cnt_out_next;
  logic               sat_out_reg, sat_out_next;

  logic               accept;
  logic               first_word;
  logic [W-1:0]       acc_word;
  logic [LEN_W-1:0]   cnt_word;
  logic               sat_word;

  always_comb begin
`ifdef XOR_PARITY_OVERLAP_EN
    in_ready = (state_reg != DONE) || out_ready;
`else
    in_ready = (state_reg != DONE);
`endif
    accept     = in_valid && in_ready;
    // Any word arriving outside an open frame starts a fresh one (DONE only with overlap).
    first_word = (state_reg != ACC);
    acc_word   = first_word ? x : (acc_reg ^ x);
    if (first_word)
      cnt_word = LEN_W'(1);
    else if (cnt_reg == CNT_MAX)
      cnt_word = CNT_MAX;
    else
      cnt_word = cnt_reg + LEN_W'(1);
    sat_word   = !first_word && (sat_acc_reg || (cnt_reg == CNT_MAX));
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    sat_acc_next = sat_acc_reg;
    z_next       = z_reg;
    p_next       = p_reg;
    cnt_out_next = cnt_out_reg;
    sat_out_next = sat_out_reg;

    if ((state_reg == DONE) && out_ready) begin
      state_next   = IDLE;
      acc_next     = '0;
      cnt_next     = '0;
      sat_acc_next = 1'b0;
    end

    // An accept in DONE can only coincide with the handoff, so it overrides the clear above.
    if (accept) begin
      acc_next     = acc_word;
      cnt_next     = cnt_word;
      sat_acc_next = sat_word;
      state_next   = in_last ? DONE : ACC;
      if (in_last) begin
        z_next       = acc_word;
        p_next       = ^acc_word;
        cnt_out_next = cnt_word;
        sat_out_next = sat_word;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      sat_acc_reg <= 1'b0;
      z_reg       <= '0;
      p_reg       <= 1'b0;
      cnt_out_reg <= '0;
      sat_out_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      sat_acc_reg <= sat_acc_next;
      z_reg       <= z_next;
      p_reg       <= p_next;
      cnt_out_reg <= cnt_out_next;
      sat_out_reg <= sat_out_next;
    end
  end

  assign out_valid = (state_reg == DONE);
  assign z         = z_reg;
  assign p         = p_reg;
  assign count     = cnt_out_reg;
  assign sat       = sat_out_reg;

endmodule

// File: tb/tb_xor_parity_accumulator.sv
// Directed bench for xor_parity_accumulator: a W=8/LEN_W=8 instance plus a LEN_W=2 instance for saturation.
module tb_xor_parity_accumulator;

  logic       clock = 1'b0;
  logic       reset_;

  logic       in_valid, in_ready, in_last, out_valid, out_ready, p, sat;
  logic [7:0] x, z, count;

  logic       s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_p, s_sat;
  logic [7:0] s_x, s_z;
  logic [1:0] s_count;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  xor_parity_accumulator #(.W(8), .LEN_W(8)) dut (
    .clock(clock), .reset_(reset_),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .p(p), .count(count), .sat(sat)
  );

  xor_parity_accumulator #(.W(8), .LEN_W(2)) dut_s (
    .clock(clock), .reset_(reset_),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .x(s_x), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .z(s_z), .p(s_p), .count(s_count), .sat(s_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each task starts and ends 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1; x = d; in_last = last;
    @(posedge clock); #1;
    in_valid = 1'b0; x = '0; in_last = 1'b0;
    $display("[TB] word x=%02h last=%0b -> out_valid=%0b z=%02h count=%0d", d, last, out_valid, z, count);
  endtask

  task automatic send_s(input logic [7:0] d, input logic last);
    s_in_valid = 1'b1; s_x = d; s_in_last = last;
    @(posedge clock); #1;
    s_in_valid = 1'b0; s_x = '0; s_in_last = 1'b0;
    $display("[TB] small word x=%02h last=%0b -> out_valid=%0b z=%02h count=%0d sat=%0b",
             d, last, s_out_valid, s_z, s_count, s_sat);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    $display("[TB] handoff -> out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  task automatic handoff_s();
    s_out_ready = 1'b1;
    @(posedge clock); #1;
    s_out_ready = 1'b0;
    $display("[TB] small handoff -> out_valid=%0b", s_out_valid);
  endtask

  initial begin
    reset_ = 1'b0;
    in_valid = 1'b0; x = '0; in_last = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_x = '0; s_in_last = 1'b0; s_out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_z",         32'(z),         32'h0);
    check("rst_p",         32'(p),         32'h0);
    check("rst_count",     32'(count),     32'h0);
    check("rst_sat",       32'(sat),       32'h0);
    @(negedge clock) reset_ = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready",  32'(in_ready),  32'h1);

    // Three-word frame: 3C ^ A5 ^ 0F = 96
    send(8'h3C, 1'b0);
    check("f1_mid_out_valid", 32'(out_valid), 32'h0);
    send(8'hA5, 1'b0);
    send(8'h0F, 1'b1);
    check("f1_out_valid", 32'(out_valid), 32'h1);
    check("f1_z",         32'(z),         32'h96);
    check("f1_p",         32'(p),         32'h0);
    check("f1_count",     32'(count),     32'h3);
    check("f1_sat",       32'(sat),       32'h0);

    // Result held while the consumer stalls
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("hold_out_valid", 32'(out_valid), 32'h1);
      check("hold_z",         32'(z),         32'h96);
      check("hold_p",         32'(p),         32'h0);
      check("hold_count",     32'(count),     32'h3);
`ifndef XOR_PARITY_OVERLAP_EN
      check("hold_in_ready",  32'(in_ready),  32'h0);
`endif
      $display("[TB] hold cycle %0d z=%02h count=%0d", i, z, count);
    end
    handoff();
    check("f1_idle_out_valid", 32'(out_valid), 32'h0);
    check("f1_idle_in_ready",  32'(in_ready),  32'h1);

    // Single-word frame
    send(8'h01, 1'b1);
    check("single_out_valid", 32'(out_valid), 32'h1);
    check("single_z",         32'(z),         32'h01);
    check("single_p",         32'(p),         32'h1);
    check("single_count",     32'(count),     32'h1);
    handoff();

    // Stalled frame: 12 ^ 34 = 26 (three ones)
    send(8'h12, 1'b0);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("stall_out_valid", 32'(out_valid), 32'h0);
    send(8'h34, 1'b1);
    check("stall_z",     32'(z),     32'h26);
    check("stall_p",     32'(p),     32'h1);
    check("stall_count", 32'(count), 32'h2);
    handoff();

    // LEN_W=2: three words reach the maximum without saturating
    send_s(8'h01, 1'b0);
    send_s(8'h02, 1'b0);
    send_s(8'h04, 1'b1);
    check("s3_out_valid", 32'(s_out_valid), 32'h1);
    check("s3_z",         32'(s_z),         32'h07);
    check("s3_count",     32'(s_count),     32'h3);
    check("s3_sat",       32'(s_sat),       32'h0);
    handoff_s();

    // LEN_W=2: five words of FF saturate
    for (int i = 0; i < 5; i++) send_s(8'hFF, (i == 4));
    check("s5_out_valid", 32'(s_out_valid), 32'h1);
    check("s5_z",         32'(s_z),         32'hFF);
    check("s5_p",         32'(s_p),         32'h0);
    check("s5_count",     32'(s_count),     32'h3);
    check("s5_sat",       32'(s_sat),       32'h1);
    handoff_s();
    check("s5_idle_out_valid", 32'(s_out_valid), 32'h0);

    // Asynchronous reset mid-frame discards the partial frame
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2 reset_ = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_count",     32'(count),     32'h0);
    check("mid_rst_z",         32'(z),         32'h0);
    #1 reset_ = 1'b1;
    @(posedge clock); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'h0);
    send(8'h55, 1'b1);
    check("post_rst_out_valid2", 32'(out_valid), 32'h1);
    check("post_rst_z",          32'(z),         32'h55);
    check("post_rst_count",      32'(count),     32'h1);
    check("post_rst_p",          32'(p),         32'h0);

    // New word offered on the handoff edge
    in_valid = 1'b1; x = 8'h0A; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
`ifdef XOR_PARITY_OVERLAP_EN
    in_valid = 1'b0; x = '0; in_last = 1'b0;
    $display("[TB] overlap handoff x=0a -> out_valid=%0b z=%02h count=%0d", out_valid, z, count);
    check("ovl_out_valid", 32'(out_valid), 32'h1);
    check("ovl_z",         32'(z),         32'h0A);
    check("ovl_count",     32'(count),     32'h1);
    check("ovl_p",         32'(p),         32'h0);
`else
    $display("[TB] handoff with word offered -> out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check("bubble_out_valid", 32'(out_valid), 32'h0);
    check("bubble_in_ready",  32'(in_ready),  32'h1);
    check("bubble_z_held",    32'(z),         32'h55);
    @(posedge clock); #1;
    in_valid = 1'b0; x = '0; in_last = 1'b0;
    $display("[TB] word x=0a accepted after bubble -> out_valid=%0b z=%02h", out_valid, z);
    check("bubble_next_out_valid", 32'(out_valid), 32'h1);
    check("bubble_next_z",         32'(z),         32'h0A);
    check("bubble_next_count",     32'(count),     32'h1);
`endif
    handoff();
    check("final_out_valid", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
